// File: rtl/load_align_w.sv
// load_align_w: W-stage load alignment and extension for the pipelined MIPS core.
// Registers the load type, effective address and destination register from M
// into W. In W it picks the addressed byte, halfword or word out of the
// data-memory read word, sign- or zero-extends it, and raises an
// address-error-on-load exception for misaligned word/halfword accesses.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   m_valid    M-stage instruction valid
//   m_lw/lh/lhu/lb/lbu  M-stage load type flags (priority lw > lh > lhu > lb > lbu)
//   m_addr     effective address
//   m_rd       destination register
//   stall      hold W register contents
//   flush      replace W register contents with a bubble (wins over stall)
//   dm_rdata   data-memory read word for the load in W
//   w_valid    a load occupies W
//   w_rd       destination register of that load
//   w_wen      register-file write enable
//   w_data     aligned, extended load result
//   w_adel     address-error-on-load
//   w_badaddr  faulting address (0 unless w_adel)
module load_align_w (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_lw,
    input  logic        m_lh,
    input  logic        m_lhu,
    input  logic        m_lb,
    input  logic        m_lbu,
    input  logic [31:0] m_addr,
    input  logic [4:0]  m_rd,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] dm_rdata,
    output logic        w_valid,
    output logic [4:0]  w_rd,
    output logic        w_wen,
    output logic [31:0] w_data,
    output logic        w_adel,
    output logic [31:0] w_badaddr
);

    localparam logic [2:0] TY_NONE = 3'd0;
    localparam logic [2:0] TY_LW   = 3'd1;
    localparam logic [2:0] TY_LH   = 3'd2;
    localparam logic [2:0] TY_LHU  = 3'd3;
    localparam logic [2:0] TY_LB   = 3'd4;
    localparam logic [2:0] TY_LBU  = 3'd5;

    logic [2:0]  m_type;
    logic        valid_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;

    logic        misaligned;
    logic        adel;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Encode the one-hot-ish M flags; earlier flags win if several are set.
    always_comb begin
        m_type = TY_NONE;
        if (m_lw) begin
            m_type = TY_LW;
        end else if (m_lh) begin
            m_type = TY_LH;
        end else if (m_lhu) begin
            m_type = TY_LHU;
        end else if (m_lb) begin
            m_type = TY_LB;
        end else if (m_lbu) begin
            m_type = TY_LBU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            type_q  <= TY_NONE;
            addr_q  <= 32'd0;
            rd_q    <= 5'd0;
        end else if (flush) begin
            valid_q <= 1'b0;
            type_q  <= TY_NONE;
            addr_q  <= 32'd0;
            rd_q    <= 5'd0;
        end else if (!stall) begin
            if (m_valid && (m_type != TY_NONE)) begin
                valid_q <= 1'b1;
                type_q  <= m_type;
                addr_q  <= m_addr;
                rd_q    <= m_rd;
            end else begin
                valid_q <= 1'b0;
                type_q  <= TY_NONE;
                addr_q  <= 32'd0;
                rd_q    <= 5'd0;
            end
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (type_q)
            TY_LW:          misaligned = (addr_q[1:0] != 2'b00);
            TY_LH, TY_LHU:  misaligned = addr_q[0];
            default:        misaligned = 1'b0;
        endcase
    end

    assign adel = valid_q & misaligned;

    // Little-endian lane selection, mirroring the store byte enables.
    always_comb begin
        byte_sel = dm_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   byte_sel = dm_rdata[7:0];
            2'b01:   byte_sel = dm_rdata[15:8];
            2'b10:   byte_sel = dm_rdata[23:16];
            default: byte_sel = dm_rdata[31:24];
        endcase
    end

    assign half_sel = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        w_data = 32'd0;
        if (valid_q && !adel) begin
            case (type_q)
                TY_LW:   w_data = dm_rdata;
                TY_LH:   w_data = {{16{half_sel[15]}}, half_sel};
                TY_LHU:  w_data = {16'd0, half_sel};
                TY_LB:   w_data = {{24{byte_sel[7]}}, byte_sel};
                TY_LBU:  w_data = {24'd0, byte_sel};
                default: w_data = 32'd0;
            endcase
        end
    end

    assign w_valid   = valid_q;
    assign w_rd      = rd_q;
    assign w_adel    = adel;
    assign w_badaddr = adel ? addr_q : 32'd0;
    assign w_wen     = valid_q & ~adel & (rd_q != 5'd0);

endmodule
